// File: rtl/plab4_net_router_tdm_sched_pkg.sv
// Shared definitions for the TDM output scheduler: FSM encoding, request
// indexing and round-robin pointer reset value.
package plab4_net_router_tdm_sched_pkg;

    typedef enum logic {
        STATE_ACTIVE = 1'b0,
        STATE_GUARD  = 1'b1
    } state_e;

    localparam int MAX_DOMAINS       = 4;
    localparam int INPUTS_PER_DOMAIN = 3;
    localparam int DOMAIN_NBITS      = $clog2(MAX_DOMAINS);

    localparam logic [2:0] RR_PTR_RESET = 3'b001;

    // Flat request/grant bit position of input i of domain d
    function automatic int req_idx(input int d, input int i);
        return d * INPUTS_PER_DOMAIN + i;
    endfunction

endpackage

// File: rtl/plab4_net_tdm_rr_slice.sv
// 3-input round-robin selector for one security domain; the one-hot pointer
// marks the highest-priority input and moves one past each granted input.
module plab4_net_tdm_rr_slice
    import plab4_net_router_tdm_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] reqs,
    output logic [2:0] grants
);

    logic [2:0] ptr;
    logic [2:0] rot;
    logic [2:0] pick;
    logic [2:0] sel;

    // Rotate so bit 0 is the pointer position, take the lowest set bit,
    // then rotate back to input order.
    always_comb begin
        rot = reqs;
        sel = 3'b000;
        case (ptr)
            3'b010:  rot = {reqs[0], reqs[2], reqs[1]};
            3'b100:  rot = {reqs[1], reqs[0], reqs[2]};
            default: rot = reqs;
        endcase
        pick = rot & (~rot + 3'd1);
        case (ptr)
            3'b010:  sel = {pick[1], pick[0], pick[2]};
            3'b100:  sel = {pick[0], pick[2], pick[1]};
            default: sel = pick;
        endcase
    end

    assign grants = en ? sel : 3'b000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= RR_PTR_RESET;
        else if (|grants)
            ptr <= {grants[1:0], grants[2]};
    end

endmodule

// File: rtl/plab4_net_router_tdm_sched.sv
// Time-division scheduler for one router output shared by security domains.
// Optional per-domain idle counters are built when PLAB4_NET_TDM_IDLE_CNT_EN is defined.
module plab4_net_router_tdm_sched
    import plab4_net_router_tdm_sched_pkg::*;
#(
    parameter int p_num_domains = 2,
    parameter int p_slot_len    = 8,
    parameter int p_guard_len   = 1,
    parameter int p_sel_nbits   = $clog2(3*p_num_domains)
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3*p_num_domains-1:0]   reqs,
    input  logic                         out_rdy,
    output logic [3*p_num_domains-1:0]   grants,
    output logic                         out_val,
    output logic [p_sel_nbits-1:0]       xbar_sel,
    output logic [DOMAIN_NBITS-1:0]      cur_domain,
    output logic                         in_guard
`ifdef PLAB4_NET_TDM_IDLE_CNT_EN
    ,
    output logic [16*p_num_domains-1:0]  idle_cnt
`endif
);

    localparam logic [7:0]              SLOT_LAST   = 8'(p_slot_len - 1);
    localparam logic [7:0]              GUARD_START = 8'(p_slot_len - p_guard_len);
    localparam logic [DOMAIN_NBITS-1:0] LAST_DOMAIN = DOMAIN_NBITS'(p_num_domains - 1);

    state_e     state;
    logic [7:0] slot_cnt;
    logic [7:0] slot_nxt;
    logic       wrap;

    assign wrap     = (slot_cnt == SLOT_LAST);
    assign slot_nxt = wrap ? 8'd0 : slot_cnt + 8'd1;

    // Slot timing is free-running: traffic never influences it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt   <= 8'd0;
            cur_domain <= '0;
            state      <= STATE_ACTIVE;
        end else begin
            slot_cnt <= slot_nxt;
            if (wrap)
                cur_domain <= (cur_domain == LAST_DOMAIN) ? '0 : cur_domain + 1'b1;
            case (state)
                STATE_ACTIVE: if (slot_nxt == GUARD_START) state <= STATE_GUARD;
                STATE_GUARD:  if (wrap) state <= STATE_ACTIVE;
                default:      state <= STATE_ACTIVE;
            endcase
        end
    end

    assign in_guard = (state == STATE_GUARD);

    logic [p_num_domains-1:0]      en;
    logic [p_num_domains-1:0][2:0] slice_grants;

    for (genvar d = 0; d < p_num_domains; d++) begin : g_dom
        localparam int BASE = req_idx(d, 0);
        // Gating with reset forces grants low the instant reset asserts.
        assign en[d] = reset && (state == STATE_ACTIVE) && out_rdy &&
                       (cur_domain == DOMAIN_NBITS'(d));
        plab4_net_tdm_rr_slice u_rr (
            .clk    (clk),
            .reset  (reset),
            .en     (en[d]),
            .reqs   (reqs[BASE +: 3]),
            .grants (slice_grants[d])
        );
    end

    assign grants  = slice_grants;
    assign out_val = |grants;

    logic [2:0] cur_grant;
    logic [1:0] gidx;

    always_comb begin
        cur_grant = 3'b000;
        for (int d = 0; d < p_num_domains; d++)
            cur_grant = cur_grant | slice_grants[d];
        case (cur_grant)
            3'b010:  gidx = 2'd1;
            3'b100:  gidx = 2'd2;
            default: gidx = 2'd0;
        endcase
    end

    // With no grant this still points at the current domain's input 0.
    assign xbar_sel = p_sel_nbits'({3'b000, cur_domain} * 5'd3 + {3'b000, gidx});

`ifdef PLAB4_NET_TDM_IDLE_CNT_EN
    logic [p_num_domains-1:0][15:0] idle_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            for (int d = 0; d < p_num_domains; d++)
                if ((cur_domain == DOMAIN_NBITS'(d)) && (state == STATE_ACTIVE) && out_rdy &&
                    (reqs[req_idx(d, 0) +: 3] == 3'b000) && (idle_q[d] != 16'hFFFF))
                    idle_q[d] <= idle_q[d] + 16'd1;
        end
    end

    assign idle_cnt = idle_q;
`endif

endmodule

// File: tb/tb_plab4_net_router_tdm_sched.sv
// Scoreboard bench for the TDM scheduler: a cycle-level reference model
// predicts each cycle's outputs, a monitor compares at the falling edge.
module tb_plab4_net_router_tdm_sched;

    localparam int ND = 2;
    localparam int SL = 8;
    localparam int GL = 1;
    localparam int NB = $clog2(3*ND);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [3*ND-1:0] reqs = '0;
    logic            out_rdy = 1'b0;
    logic [3*ND-1:0] grants;
    logic            out_val;
    logic [NB-1:0]   xbar_sel;
    logic [1:0]      cur_domain;
    logic            in_guard;

    logic [8:0]      reqs3 = '0;
    logic [8:0]      grants3;
    logic            out_val3;
    logic [3:0]      xbar_sel3;
    logic [1:0]      cur_domain3;
    logic            in_guard3;

`ifdef PLAB4_NET_TDM_IDLE_CNT_EN
    logic [16*ND-1:0] idle_cnt;
    logic [47:0]      idle_cnt3;
`endif

    always #5 clk = ~clk;

    plab4_net_router_tdm_sched #(.p_num_domains(ND), .p_slot_len(SL), .p_guard_len(GL)) u_dut (
        .clk(clk), .reset(reset), .reqs(reqs), .out_rdy(out_rdy),
        .grants(grants), .out_val(out_val), .xbar_sel(xbar_sel),
        .cur_domain(cur_domain), .in_guard(in_guard)
`ifdef PLAB4_NET_TDM_IDLE_CNT_EN
        , .idle_cnt(idle_cnt)
`endif
    );

    plab4_net_router_tdm_sched #(.p_num_domains(3), .p_slot_len(4), .p_guard_len(2)) u_dut3 (
        .clk(clk), .reset(reset), .reqs(reqs3), .out_rdy(out_rdy),
        .grants(grants3), .out_val(out_val3), .xbar_sel(xbar_sel3),
        .cur_domain(cur_domain3), .in_guard(in_guard3)
`ifdef PLAB4_NET_TDM_IDLE_CNT_EN
        , .idle_cnt(idle_cnt3)
`endif
    );

    typedef struct {
        int              cyc;
        logic [3*ND-1:0] grants;
        logic            val;
        logic [NB-1:0]   sel;
        logic [1:0]      dom;
        logic            guard;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_q[$];
    int   errors = 0;
    int   checks = 0;
    int   t;
    int   ptr[ND];
    int   idle[ND];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int d = 0; d < ND; d++) begin
            ptr[d]  = 0;
            idle[d] = 0;
        end
    endtask

    // Reference: slot position from elapsed cycles, round-robin by index.
    task automatic step(input logic [3*ND-1:0] r, input logic rdy);
        exp_t       e;
        int         dom;
        int         pos;
        bit         act;
        logic [2:0] s;
        dom = (t / SL) % ND;
        pos = t % SL;
        act = pos < (SL - GL);
        s = r[dom*3 +: 3];
        e.cyc = t;
        e.grants = '0;
        e.val = 1'b0;
        e.sel = NB'(dom*3);
        e.dom = 2'(dom);
        e.guard = !act;
        if (act && rdy) begin
            if (s == 3'b000) idle[dom]++;
            else begin
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (ptr[dom] + k) % 3;
                    if (s[i]) begin
                        e.grants[dom*3 + i] = 1'b1;
                        e.val = 1'b1;
                        e.sel = NB'(dom*3 + i);
                        ptr[dom] = (i + 1) % 3;
                        xfer_q.push_back(dom*3 + i);
                        break;
                    end
                end
            end
        end
        reqs = r;
        out_rdy = rdy;
        exp_q.push_back(e);
        t++;
        @(posedge clk);
        #1;
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            check("grants", 32'(grants), 32'(m.grants));
            check("out_val", 32'(out_val), 32'(m.val));
            check("xbar_sel", 32'(xbar_sel), 32'(m.sel));
            check("cur_domain", 32'(cur_domain), 32'(m.dom));
            check("in_guard", 32'(in_guard), 32'(m.guard));
            check("dut3_cur_domain", 32'(cur_domain3), 32'((m.cyc / 4) % 3));
            check("dut3_in_guard", 32'(in_guard3), 32'((m.cyc % 4) >= 2));
            if (out_val && out_rdy) begin
                if (xfer_q.size() == 0) check("xfer_unexpected", 32'(xbar_sel), 32'hFFFF_FFFF);
                else check("xfer_sel", 32'(xbar_sel), 32'(xfer_q.pop_front()));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grants"}, 32'(grants), 32'd0);
        check({tag, "_out_val"}, 32'(out_val), 32'd0);
        check({tag, "_xbar_sel"}, 32'(xbar_sel), 32'd0);
        check({tag, "_cur_domain"}, 32'(cur_domain), 32'd0);
        check({tag, "_in_guard"}, 32'(in_guard), 32'd0);
    endtask

    task automatic check_idle();
`ifdef PLAB4_NET_TDM_IDLE_CNT_EN
        for (int d = 0; d < ND; d++)
            check("idle_cnt", 32'(idle_cnt[d*16 +: 16]), 32'(idle[d]));
`endif
    endtask

    initial begin
        model_reset();
        reqs = '1;
        out_rdy = 1'b1;
        #12;
        check_reset_outputs("reset_held");
        @(posedge clk);
        #1 reset = 1'b1;

        // Domain 1 input 0 only: grants in cycles 8..14 and 24..30.
        for (int c = 0; c < 32; c++) step(6'b001000, 1'b1);
        // Every input of both domains requesting.
        for (int c = 0; c < 32; c++) step('1, 1'b1);
        // Downstream stall at cycles 2..4 of a domain 0 slot.
        for (int c = 0; c < 16; c++) step('1, !(c >= 2 && c <= 4));
        for (int c = 0; c < 400; c++) step(6'($urandom), $urandom_range(0, 3) != 0);

        // Asynchronous reset in cycle 5 of a domain 1 slot with traffic pending.
        for (int c = 0; c < 13; c++) step('1, 1'b1);
        check_idle();
        reqs = '1;
        out_rdy = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(posedge clk);
        #1 check_reset_outputs("reset_after_edge");
        check_idle();
        model_reset();
        reset = 1'b1;
        for (int c = 0; c < 48; c++) step(6'($urandom), $urandom_range(0, 3) != 0);
        check_idle();

        #20;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("xfer_q_drained", 32'(xfer_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
